// File: rtl/tx_packet_fifo.sv
// tx_packet_fifo: byte buffer with packet commit/abort and a descriptor
// FIFO, drained through a req/ack/strobe client port.
module tx_packet_fifo #(
   parameter int aw       = 11,
   parameter int jumbo_dw = 14,
   parameter int pw       = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          wr_data,
   input  logic                wr_en,
   input  logic                wr_last,
   input  logic                wr_abort,
   output logic                req,
   output logic [jumbo_dw-1:0] length,
   input  logic                ack,
   input  logic                strobe,
   output logic [7:0]          data_out,
   output logic [7:0]          drop_count,
   output logic                full
);
   localparam int Depth  = 1 << aw;
   localparam int DDepth = 1 << pw;

   typedef enum logic [1:0] {IDLE, GRANTED, DONE} state_t;
   state_t state_q, state_d;

   logic                rst_sync_q;
   logic                run;
   logic [7:0]          mem  [Depth];
   logic [jumbo_dw-1:0] dmem [DDepth];
   logic [aw-1:0]       wp_q, wp_d, cp_q, cp_d;
   logic [aw-1:0]       rp_q, rp_d, fp_q, fp_d;
   logic [jumbo_dw-1:0] len_q, len_d, rcnt_q, rcnt_d;
   logic [pw-1:0]       dwp_q, drp_q;
   logic [pw:0]         dcnt_q;
   logic                bad_q, bad_d;
   logic [7:0]          drop_q, drop_d, data_q, data_d;
   logic                store, push, pop, rd_take, grant;
   logic                desc_full, bad_now;
   logic [jumbo_dw-1:0] head;

   // Logic is held idle for the first edge after rst falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_sync_q <= 1'b1;
      else     rst_sync_q <= 1'b0;
   end

   assign run        = ~rst_sync_q;
   assign desc_full  = dcnt_q[pw];
   assign head       = (dcnt_q != '0) ? dmem[drp_q] : '0;
   assign full       = (wp_q + 1'b1) == fp_q;
   assign bad_now    = bad_q | full | (&len_q) | (wr_last & desc_full);
   assign length     = head;
   assign data_out   = data_q;
   assign drop_count = drop_q;

   always_comb begin
      wp_d   = wp_q;
      cp_d   = cp_q;
      len_d  = len_q;
      bad_d  = bad_q;
      drop_d = drop_q;
      store  = 1'b0;
      push   = 1'b0;
      if (run && wr_abort) begin
         wp_d  = cp_q;
         len_d = '0;
         bad_d = 1'b0;
      end else if (run && wr_en) begin
         if (bad_now) begin
            if (wr_last) begin
               wp_d  = cp_q;
               len_d = '0;
               bad_d = 1'b0;
               if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else begin
               bad_d = 1'b1;
            end
         end else begin
            store = 1'b1;
            wp_d  = wp_q + 1'b1;
            len_d = len_q + 1'b1;
            if (wr_last) begin
               cp_d  = wp_q + 1'b1;
               push  = 1'b1;
               len_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (store) mem[wp_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (push) dmem[dwp_q] <= len_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant) state_d = GRANTED;
         GRANTED: if (pop) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req     = 1'b0;
      grant   = 1'b0;
      rd_take = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            req   = dcnt_q != '0;
            grant = run & ack & req;
         end
         GRANTED: begin
            rd_take = run & strobe;
            pop     = rd_take & ((rcnt_q + 1'b1) == head);
         end
         default: ;
      endcase
   end

   // The final strobe of a packet frees its bytes back to the writer.
   always_comb begin
      rp_d   = rp_q;
      fp_d   = fp_q;
      rcnt_d = rcnt_q;
      data_d = data_q;
      if (grant) rcnt_d = '0;
      if (rd_take) begin
         data_d = mem[rp_q];
         rp_d   = rp_q + 1'b1;
         rcnt_d = rcnt_q + 1'b1;
         if (pop) fp_d = rp_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q   <= '0;
         cp_q   <= '0;
         rp_q   <= '0;
         fp_q   <= '0;
         len_q  <= '0;
         rcnt_q <= '0;
         bad_q  <= 1'b0;
         drop_q <= '0;
         data_q <= '0;
         dwp_q  <= '0;
         drp_q  <= '0;
         dcnt_q <= '0;
      end else begin
         wp_q   <= wp_d;
         cp_q   <= cp_d;
         rp_q   <= rp_d;
         fp_q   <= fp_d;
         len_q  <= len_d;
         rcnt_q <= rcnt_d;
         bad_q  <= bad_d;
         drop_q <= drop_d;
         data_q <= data_d;
         if (push) dwp_q <= dwp_q + 1'b1;
         if (pop)  drp_q <= drp_q + 1'b1;
         case ({push, pop})
            2'b10:   dcnt_q <= dcnt_q + 1'b1;
            2'b01:   dcnt_q <= dcnt_q - 1'b1;
            default: dcnt_q <= dcnt_q;
         endcase
      end
   end
endmodule

// File: tb/tb_tx_packet_fifo.sv
// tb_tx_packet_fifo: directed checks of commit, abort, drop, wrap, reset
// and the req/ack/strobe read port of tx_packet_fifo.
module tb_tx_packet_fifo;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  wr_data = 8'h00;
   logic        wr_en = 1'b0;
   logic        wr_last = 1'b0;
   logic        wr_abort = 1'b0;
   logic        ack = 1'b0;
   logic        strobe = 1'b0;
   logic        req;
   logic        full;
   logic [13:0] length;
   logic [7:0]  data_out;
   logic [7:0]  drop_count;
   int passed = 0;
   int failed = 0;
   int total  = 0;

   tx_packet_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .wr_last    (wr_last),
      .wr_abort   (wr_abort),
      .req        (req),
      .length     (length),
      .ack        (ack),
      .strobe     (strobe),
      .data_out   (data_out),
      .drop_count (drop_count),
      .full       (full)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_pkt(input int start, input int n, input bit last);
      for (int i = 0; i < n; i++) begin
         wr_data = 8'((start + i) % 256);
         wr_en   = 1'b1;
         wr_last = last && (i == n - 1);
         tick();
      end
      wr_en   = 1'b0;
      wr_last = 1'b0;
   endtask

   task automatic read_pkt(input string tag, input int len,
                           input int start, input int gap);
      for (int k = 0; k < 20 && req !== 1'b1; k++) tick();
      chk({tag, " req"}, 32'(req), 1);
      chk({tag, " len"}, 32'(length), len);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk({tag, " granted"}, 32'(req), 0);
      for (int i = 0; i < len; i++) begin
         strobe = 1'b1;
         tick();
         strobe = 1'b0;
         chk({tag, " data"}, 32'(data_out), (start + i) % 256);
         if (i == len - 1) begin
            chk({tag, " done"}, 32'(req), 0);
         end else begin
            for (int g = 0; g < gap; g++) begin
               tick();
               chk({tag, " hold"}, 32'(data_out), (start + i) % 256);
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      // reset values and synchronised release
      tick();
      tick();
      chk("rst req", 32'(req), 0);
      chk("rst len", 32'(length), 0);
      chk("rst data", 32'(data_out), 0);
      chk("rst full", 32'(full), 0);
      chk("rst drop", 32'(drop_count), 0);
      rst     = 1'b0;
      wr_data = 8'h5A;
      wr_en   = 1'b1;
      wr_last = 1'b1;
      tick();
      wr_en   = 1'b0;
      wr_last = 1'b0;
      chk("sync ignore", 32'(req), 0);
      tick();

      // 64-byte packet
      write_pkt(0, 63, 1'b0);
      chk("p64 no commit", 32'(req), 0);
      write_pkt(63, 1, 1'b1);
      chk("p64 req", 32'(req), 1);
      chk("p64 len", 32'(length), 64);
      read_pkt("p64", 64, 0, 0);
      tick();
      chk("p64 empty", 32'(req), 0);

      // three packets served in order, one with gapped strobes
      write_pkt(8'hA0, 1, 1'b1);
      write_pkt(8'h10, 5, 1'b1);
      write_pkt(8'h40, 300, 1'b1);
      read_pkt("p1", 1, 8'hA0, 0);
      read_pkt("p5", 5, 8'h10, 1);
      read_pkt("p300", 300, 8'h40, 0);
      repeat (3) tick();
      chk("p3 empty", 32'(req), 0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      chk("ack ignored", 32'(req), 0);

      // abort, abort priority, then commit overlapped with retire
      write_pkt(8'h50, 10, 1'b0);
      wr_abort = 1'b1;
      wr_en    = 1'b1;
      wr_last  = 1'b1;
      wr_data  = 8'hFF;
      tick();
      wr_abort = 1'b0;
      wr_en    = 1'b0;
      wr_last  = 1'b0;
      tick();
      chk("abort req", 32'(req), 0);
      write_pkt(8'hC0, 4, 1'b1);
      chk("abort len", 32'(length), 4);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         strobe = 1'b1;
         tick();
         strobe = 1'b0;
         chk("abort data", 32'(data_out), 8'hC0 + i);
      end
      strobe  = 1'b1;
      wr_data = 8'h99;
      wr_en   = 1'b1;
      wr_last = 1'b1;
      tick();
      strobe  = 1'b0;
      wr_en   = 1'b0;
      wr_last = 1'b0;
      chk("abort last", 32'(data_out), 8'hC3);
      chk("overlap done", 32'(req), 0);
      tick();
      chk("overlap req", 32'(req), 1);
      chk("overlap len", 32'(length), 1);
      chk("abort drop", 32'(drop_count), 0);
      read_pkt("overlap", 1, 8'h99, 0);

      // packet straddling the buffer wrap
      do_reset();
      write_pkt(0, 2040, 1'b1);
      read_pkt("filler", 2040, 0, 0);
      write_pkt(8'hE0, 20, 1'b1);
      read_pkt("wrap", 20, 8'hE0, 0);

      // overfill drops the packet
      do_reset();
      write_pkt(0, 2047, 1'b0);
      chk("fill full", 32'(full), 1);
      chk("fill req", 32'(req), 0);
      write_pkt(8'hFF, 1, 1'b1);
      chk("drop count", 32'(drop_count), 1);
      chk("drop req", 32'(req), 0);
      chk("drop full", 32'(full), 0);
      write_pkt(8'h30, 3, 1'b1);
      read_pkt("after drop", 3, 8'h30, 0);
      chk("drop kept", 32'(drop_count), 1);

      // descriptor FIFO full and drop_count saturation
      do_reset();
      for (int i = 1; i <= 4; i++) write_pkt(i, 1, 1'b1);
      for (int i = 0; i < 260; i++) write_pkt(8'hEE, 1, 1'b1);
      chk("sat drop", 32'(drop_count), 255);
      for (int i = 1; i <= 4; i++) read_pkt("dfull", 1, i, 0);
      tick();
      chk("dfull empty", 32'(req), 0);

      // reset in the middle of a read
      do_reset();
      write_pkt(8'h60, 8, 1'b1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         strobe = 1'b1;
         tick();
         strobe = 1'b0;
         chk("mid data", 32'(data_out), 8'h60 + i);
      end
      rst = 1'b1;
      #2;
      chk("mid rst req", 32'(req), 0);
      chk("mid rst drop", 32'(drop_count), 0);
      chk("mid rst data", 32'(data_out), 0);
      tick();
      rst = 1'b0;
      tick();
      chk("post rst req", 32'(req), 0);
      write_pkt(8'h77, 2, 1'b1);
      read_pkt("post rst", 2, 8'h77, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/tx_packet_fifo.md
TX_PACKET_FIFO -- requirements
Module: tx_packet_fifo

Interface
REQ-001 Parameter aw, default 11: byte-buffer address width, 2^aw bytes of storage.
REQ-002 Parameter jumbo_dw, default 14: packet length width, matching the client-port length width.
REQ-003 Parameter pw, default 2: descriptor-FIFO address width, up to 2^pw committed packets.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wr_data  in  8  producer byte.
REQ-007 wr_en  in  1  byte valid on wr_data.
REQ-008 wr_last  in  1  qualified by wr_en; marks the final byte of a packet.
REQ-009 wr_abort  in  1  discards the packet being written.
REQ-010 req  out  1  committed packet available; connects to the aggregate client req.
REQ-011 length  out  jumbo_dw  byte count of the head packet.
REQ-012 ack  in  1  one-cycle grant from the aggregate.
REQ-013 strobe  in  1  byte request from the aggregate (warn/strobe_tx).
REQ-014 data_out  out  8  head-packet byte; valid the cycle after the strobe that requested it.
REQ-015 drop_count  out  8  saturating count of discarded packets.
REQ-016 full  out  1  byte buffer has no free location.

Function
REQ-017 Bytes SHALL be written at a write pointer; the committed pointer SHALL advance to the write pointer only on wr_en&wr_last.
REQ-018 On commit, the packet length (bytes since the last commit/abort, including the last byte) SHALL be pushed to the descriptor FIFO.
REQ-019 req SHALL be high whenever the descriptor FIFO is non-empty and the read FSM is IDLE; length SHALL equal the head descriptor.
REQ-020 Read FSM states SHALL be IDLE, GRANTED and DONE.
REQ-021 IDLE->GRANTED on ack while req=1; ack while req=0 SHALL be ignored.
REQ-022 In GRANTED, each strobe SHALL read one byte at the read pointer, which then increments modulo 2^aw; strobes may be non-contiguous.
REQ-023 The read latency SHALL be exactly 1 cycle; data_out SHALL hold its last value when there is no strobe.
REQ-024 When the length-th strobe occurs, the FSM SHALL go GRANTED->DONE, pop the descriptor and free the packet's bytes.
REQ-025 DONE->IDLE SHALL occur unconditionally after 1 cycle, so req is low for at least 1 cycle between packets.
REQ-026 Strobes in IDLE or DONE, or beyond length, SHALL NOT move the read pointer.
REQ-027 wr_abort SHALL rewind the write pointer to the committed pointer; wr_abort has priority over wr_en in the same cycle.
REQ-028 A wr_en while full, a packet length exceeding 2^jumbo_dw-1, or a wr_last while the descriptor FIFO is full SHALL mark the packet bad.
REQ-029 A bad packet SHALL be rewound at its wr_last, SHALL NOT be committed, and SHALL increment drop_count, saturating at 255.
REQ-030 Bytes written while bad SHALL NOT be stored.
REQ-031 full SHALL equal (write pointer + 1 == read-side free pointer) modulo 2^aw, giving a usable capacity of 2^aw-1 bytes.
REQ-032 Pointers SHALL wrap modulo 2^aw, and packets SHALL be allowed to straddle the wrap.
REQ-033 A commit and a retire in the same cycle SHALL both take effect, leaving the descriptor count unchanged.
REQ-034 A 1-byte packet (wr_en&wr_last with no preceding bytes) SHALL be legal, with length=1.

Reset
REQ-035 rst SHALL clear all pointers, the descriptor FIFO, the bad flag and drop_count, and SHALL put the FSM in IDLE.
REQ-036 Under rst: req=0, length=0, data_out=0, full=0, drop_count=0.
REQ-037 rst during a write or a read SHALL discard all buffered and in-flight packets, and no partial packet SHALL survive.
REQ-038 Reset deassertion SHALL be synchronised internally; first writes are accepted on the 2nd clk after rst falls.

Verification
REQ-039 Write 64 bytes 0x00..0x3F with wr_last on 0x3F -> req=1 and length=64 the next cycle; ack then 64 strobes -> data_out 0x00..0x3F each 1 cycle after its strobe; req=0 for at least 1 cycle.
REQ-040 Commit three packets of lengths 1, 5 and 300 -> served in order, each with the correct length and bytes; after the third packet, req stays 0.
REQ-041 Start a packet at pointer 2040 with aw=11 and length 20 -> bytes read back intact across the wrap.
REQ-042 Write 10 bytes, assert wr_abort, then write a 4-byte packet -> length=4, only the new bytes are returned, drop_count=0.
REQ-043 Fill 2047 bytes with no wr_last, then one more byte with wr_last -> full=1, packet dropped, drop_count=1, req=0, and the buffer is empty again.
REQ-044 Assert rst mid-read after 3 of 8 strobes -> req=0 and drop_count=0; a subsequent 2-byte packet reads back correctly.
